// File: rtl/bs_pkg.sv
// Shared types and widths for the bs query sequencer.
package bs_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    START,
    WAIT
  } bsq_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] target;
    logic              found;
    logic [ADDR_W-1:0] loc;
    logic              timeout;
  } bsq_result_t;

endpackage

// File: rtl/bsq_fifo.sv
// Small circular-buffer FIFO holding search targets. Pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module bsq_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout  = mem[rd_ptr[PW-1:0]];

  // Pointer advance; the low bits wrap modulo DEPTH, the top bit toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/bs_query_sequencer.sv
// Front-end for the bs binary-search block: queues targets, presents each on
// A with setup margin, pulses Start, captures Found/Loc on a fresh Done edge
// and returns the result on a valid/ready port.
// Optional build macro BSQ_TIMEOUT_EN adds a WAIT watchdog that posts a
// timeout result after TIMEOUT_CYC cycles without a Done edge.
module bs_query_sequencer
  import bs_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [DATA_W-1:0] q_target,
  output logic [DATA_W-1:0] A,
  output logic              Start,
  input  logic              Done,
  input  logic              Found,
  input  logic [ADDR_W-1:0] Loc,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_target,
  output logic              r_found,
  output logic [ADDR_W-1:0] r_loc,
  output logic              r_timeout
);

  localparam int               CNT_W      = $clog2(SETUP_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);

  bsq_state_t        state;
  bsq_state_t        nstate;
  logic [CNT_W-1:0]  set_cnt;
  logic [DATA_W-1:0] a_q;
  logic              done_q;
  logic              done_rise;
  bsq_result_t       res_q;
  logic              r_valid_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              push;
  logic              pop;
  logic              cap;
  logic              to_hit;

  assign push      = q_valid && !fifo_full;
  assign q_ready   = !fifo_full;
  assign done_rise = Done && !done_q;
  assign A         = a_q;
  assign Start     = (state == START);
  assign r_valid   = r_valid_q;
  assign r_target  = res_q.target;
  assign r_found   = res_q.found;
  assign r_loc     = res_q.loc;
  assign r_timeout = res_q.timeout;

  bsq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (Reset),
    .push  (push),
    .pop   (pop),
    .din   (q_target),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef BSQ_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] wait_cnt;

  // A Done edge on the final WAIT cycle takes priority over the timeout.
  assign to_hit = (state == WAIT) && !done_rise && (wait_cnt == TO_LAST);

  // WAIT watchdog: cleared while in START so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= '0;
    end else if (state == START) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;

  // TIMEOUT_CYC only shapes the watchdog build; kept so both builds share one interface.
  if (TIMEOUT_CYC < 1) begin : g_timeout_cyc_unused
  end
`endif

  // Next-state and issue/capture decisions.
  always_comb begin
    nstate = state;
    pop    = 1'b0;
    cap    = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending result holds off the next issue; this is the backpressure path.
        if (!fifo_empty && !r_valid_q) begin
          pop    = 1'b1;
          nstate = SETUP;
        end
      end
      SETUP: begin
        if (set_cnt == SETUP_LAST) nstate = START;
      end
      START: begin
        nstate = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          cap    = 1'b1;
          nstate = IDLE;
        end else if (to_hit) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // State, A register, setup counter and Done history.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      a_q     <= '0;
      set_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= nstate;
      done_q <= Done;
      if (pop) begin
        a_q     <= fifo_dout;
        set_cnt <= '0;
      end else if (state == SETUP && set_cnt != SETUP_LAST) begin
        set_cnt <= set_cnt + 1'b1;
      end
    end
  end

  // Result slot: filled on capture or timeout, emptied by the consumer handshake.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      res_q     <= '0;
      r_valid_q <= 1'b0;
    end else if (cap) begin
      res_q.target  <= a_q;
      res_q.found   <= Found;
      res_q.loc     <= Found ? Loc : '0;
      res_q.timeout <= 1'b0;
      r_valid_q     <= 1'b1;
    end else if (to_hit) begin
      res_q.target  <= a_q;
      res_q.found   <= 1'b0;
      res_q.loc     <= '0;
      res_q.timeout <= 1'b1;
      r_valid_q     <= 1'b1;
    end else if (r_ready) begin
      r_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/bs_query_sequencer.md
Name: bs_query_sequencer

Overview:
- Upstream front-end for the bs binary-search block.
- Buffers incoming search targets in a small FIFO and presents each target on bs's A input with setup margin, then pulses Start.
- Waits for Done, captures Found/Loc, and returns {target, found, loc} on a valid/ready result port.
- Lets a producer stream many queries back-to-back without knowing bs timing.

Parameters:
- DEPTH, 4: target FIFO entries; power of two, minimum 2.
- SETUP_CYC, 2: cycles A is held stable before Start is asserted; minimum 1.
- TIMEOUT_CYC, 64: cycles to wait for Done before aborting; used only with BSQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- q_valid  in  1  producer has a target.
- q_ready  out  1  FIFO not full; transfer when q_valid && q_ready.
- q_target  in  8  search value.
- A  out  8  target driven to bs.
- Start  out  1  one-cycle start pulse to bs.
- Done  in  1  bs completion level.
- Found  in  1  bs hit flag, sampled on the Done rising edge.
- Loc  in  5  bs hit address, sampled on the Done rising edge.
- r_valid  out  1  result slot full.
- r_ready  in  1  consumer accepts the result.
- r_target  out  8  target of this result.
- r_found  out  1  hit flag.
- r_loc  out  5  address on a hit; 0 on a miss.
- r_timeout  out  1  search aborted (tied 0 without BSQ_TIMEOUT_EN).

Behaviour:
- Reset (Reset=0, asynchronous): FIFO empty, q_ready=1, A=0, Start=0, r_valid=0, r_target=0, r_found=0, r_loc=0, r_timeout=0, state IDLE, setup counter 0, Done history register 0.
- FIFO: circular buffer with log2(DEPTH)-bit pointers plus a wrap bit. q_ready = !full.
  - Push when q_valid && q_ready.
  - Pop only on the IDLE->SETUP transition.
  - A simultaneous push and pop while full is not possible, because q_ready is 0 when full.
  - A simultaneous push and pop while empty is not possible either: IDLE requires non-empty.
  - Pointers wrap modulo DEPTH.
- States:
  - IDLE: if FIFO non-empty and r_valid=0, pop the head into the A register, clear the counter, go to SETUP. r_valid=1 blocks issue; this is the backpressure.
  - SETUP: increment the counter each cycle; when counter == SETUP_CYC-1, go to START.
  - START: Start=1 for exactly this cycle; go to WAIT.
  - WAIT: detect a Done rising edge (Done && !done_q). On the edge, register r_target=A, r_found=Found, r_loc = Found ? Loc : 0, set r_valid=1, go to IDLE.
- A is held constant from SETUP through the cycle of Done capture.
- Done history register: done_q is updated every cycle in every state. A Done level already high on entry to WAIT does not count as completion; only a fresh rising edge does.
- Result handshake: the result is accepted when r_valid && r_ready, and r_valid clears next cycle. The r_* fields are stable while r_valid=1 and r_ready=0.
- Latency: the first target pushed into an empty FIFO in IDLE produces Start on cycle 3+SETUP_CYC after the push edge (push, IDLE pop, SETUP cycles, START). The result appears 1 cycle after the Done rising edge.
- Reset mid-operation: everything returns to the reset values immediately. Queued targets and any in-flight search are discarded. Start is never left asserted.

Optional Feature:
- Macro BSQ_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter clears on entering WAIT.
  - If it reaches TIMEOUT_CYC-1 with no Done rising edge, the block posts a result with r_target=A, r_found=0, r_loc=0, r_timeout=1, r_valid=1, and returns to IDLE.
  - A Done edge in the same cycle as the timeout wins: normal result, r_timeout=0.
- Undefined: no counter; WAIT waits indefinitely; r_timeout tied 0.

Decomposition:
- Package bs_pkg:
  - constants DATA_W=8, ADDR_W=5;
  - typedef enum logic [1:0] {IDLE, SETUP, START, WAIT} bsq_state_t;
  - typedef struct packed {target, found, loc, timeout} bsq_result_t.
- Sub-module bsq_fifo: parameterised DEPTH × DATA_W synchronous FIFO with push/pop/full/empty and asynchronous active-low reset. The sequencer FSM stays in the top.

Test Plan:
- Full sweep with real bs: push targets 0..33 with r_ready=1 and SETUP_CYC=2 -> 34 results in order. Targets 1..32 give r_found=1, r_loc=target-1; targets 0 and 33 give r_found=0, r_loc=0. Start pulses exactly 34 times, each exactly 1 cycle wide.
- Setup timing: push 7 into an idle block -> A=7 for ≥2 cycles before Start=1; A unchanged until the result. Result r_target=7, r_loc=6.
- Backpressure: r_ready=0, push 5,10,15,20,25 with DEPTH=4.
  - First result (5) held.
  - q_ready drops once 4 entries are queued.
  - No second Start until r_ready=1.
  - Then results 5,10,15,20,25 arrive in order, with r_loc 4,9,14,19,24.
- Stale Done: model bs holding Done=1 from the previous search into the next WAIT -> no capture until Done falls and rises again. The result matches the new target.
- Reset mid-search: assert Reset low during WAIT with 3 entries queued -> q_ready=1, r_valid=0, Start=0 immediately. After release, push 12 -> a single result with r_loc=11.
- BSQ_TIMEOUT_EN, TIMEOUT_CYC=16: stub bs never raises Done; push 9 -> after 16 WAIT cycles, r_valid=1, r_timeout=1, r_found=0, r_target=9. The next queued target proceeds normally.
